// File: rtl/cam_write_port_if.sv
// Request and CAM-array signal bundle for the CAM write port.
// The master side is the requester plus search logic; the slave side is the write port.
interface cam_write_port_if #(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned IDX_W   = 5,
    parameter int unsigned DATA_W  = 32
) ();
    logic               wr_valid;
    logic               wr_ready;
    logic [IDX_W-1:0]   wr_index;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_invalidate;
    logic               search_busy;
    logic [ENTRIES-1:0] entry_we;
    logic [DATA_W-1:0]  entry_data;
    logic               entry_valid_bit;
    logic               wr_done;
    logic               wr_err;

    modport master (
        output wr_valid, wr_index, wr_data, wr_invalidate, search_busy,
        input  wr_ready, entry_we, entry_data, entry_valid_bit, wr_done, wr_err
    );

    modport slave (
        input  wr_valid, wr_index, wr_data, wr_invalidate, search_busy,
        output wr_ready, entry_we, entry_data, entry_valid_bit, wr_done, wr_err
    );
endinterface

// File: rtl/cam_write_port.sv
// CAM write port: takes one write/invalidate request at a time and issues a single-cycle
// one-hot entry write, deferring while a search runs and dropping on bad index or timeout.
module cam_write_port #(
    parameter int unsigned ENTRIES   = 32,
    parameter int unsigned IDX_W     = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned STALL_MAX = 15
) (
    input logic           clk,
    input logic           reset_n,
    cam_write_port_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(STALL_MAX + 2);

    typedef enum logic [1:0] {StIdle, StPending, StCommit} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               inv_q, inv_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [ENTRIES-1:0] entry_we_q, entry_we_d;
    logic [DATA_W-1:0]  entry_data_q, entry_data_d;
    logic               valid_bit_q, valid_bit_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               wr_ready;
    logic               idx_bad;
    logic [ENTRIES-1:0] we_dec;

    assign wr_ready = (state_q == StIdle) && !bus.search_busy && reset_n;
    assign idx_bad  = 32'(idx_q) >= ENTRIES;

    always_comb begin
        we_dec = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            we_dec[i] = (32'(idx_q) == i);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        data_d       = data_q;
        inv_d        = inv_q;
        stall_d      = stall_q;
        entry_we_d   = '0;
        entry_data_d = entry_data_q;
        valid_bit_d  = valid_bit_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.wr_valid && wr_ready) begin
                    idx_d   = bus.wr_index;
                    data_d  = bus.wr_data;
                    inv_d   = bus.wr_invalidate;
                    stall_d = '0;
                    state_d = StPending;
                end
            end
            StPending: begin
                // Bad index is reported even while a search holds off the commit.
                if (idx_bad) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (!bus.search_busy) begin
                    entry_we_d   = we_dec;
                    entry_data_d = data_q;
                    valid_bit_d  = !inv_q;
                    state_d      = StCommit;
                end else if (stall_q == CNT_W'(STALL_MAX)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            StCommit: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            data_q       <= '0;
            inv_q        <= 1'b0;
            stall_q      <= '0;
            entry_we_q   <= '0;
            entry_data_q <= '0;
            valid_bit_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            inv_q        <= inv_d;
            stall_q      <= stall_d;
            entry_we_q   <= entry_we_d;
            entry_data_q <= entry_data_d;
            valid_bit_q  <= valid_bit_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.wr_ready        = wr_ready;
    assign bus.entry_we        = entry_we_q;
    assign bus.entry_data      = entry_data_q;
    assign bus.entry_valid_bit = valid_bit_q;
    assign bus.wr_done         = done_q;
    assign bus.wr_err          = err_q;
endmodule
